// File: rtl/mouse_scale_sequencer.sv
// mouse_scale_sequencer
// Scales raw PS/2 pointer coordinates (960x640 space) down to 96x64 OLED
// pixel coordinates by dividing each axis by DIVISOR and clamping to the
// panel edge. One iterative restoring divider is shared between the axes:
// X is divided first, then Y, and both results are committed together.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   req          new-sample strobe, level sampled every edge
//   xpos, ypos   raw coordinates, valid while req=1
//   x_scale_pos  registered scaled X (clamped to X_MAX)
//   y_scale_pos  registered scaled Y (clamped to Y_MAX)
//   done         one-cycle pulse: scaled outputs just updated
//   busy         high while a conversion is in progress or committing
module mouse_scale_sequencer #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned OUT_W   = 7,
    parameter int unsigned DIVISOR = 10,
    parameter int unsigned X_MAX   = 95,
    parameter int unsigned Y_MAX   = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    output logic [OUT_W-1:0]   x_scale_pos,
    output logic [OUT_W-1:0]   y_scale_pos,
    output logic               done,
    output logic               busy
);

    localparam int unsigned REM_W = COORD_W + 1;
    localparam int unsigned CNT_W = (COORD_W > 1) ? $clog2(COORD_W) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIV_X  = 2'd1;
    localparam logic [1:0] S_DIV_Y  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [REM_W-1:0]   DIV_V    = REM_W'(DIVISOR);
    localparam logic [COORD_W-1:0] XMAX_V   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMAX_V   = COORD_W'(Y_MAX);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(COORD_W - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;

    // divider datapath
    logic [COORD_W-1:0] dvd;
    logic [COORD_W-1:0] rem;
    logic [COORD_W-1:0] quo;
    logic [CNT_W-1:0]   cnt;
    logic [COORD_W-1:0] lat_y;
    logic [COORD_W-1:0] qx;

    // coalesced request captured while busy (latest wins)
    logic               pend;
    logic [COORD_W-1:0] pend_x;
    logic [COORD_W-1:0] pend_y;

    // one restoring step
    logic [REM_W-1:0]   trial;
    logic               q_bit;
    logic [COORD_W-1:0] rem_nxt;
    logic [COORD_W-1:0] quo_nxt;
    logic               last_iter;

    // FSM control
    logic               start;
    logic               next_y;
    logic               iter;
    logic               set_pend;
    logic               clr_pend;
    logic               commit;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        trial     = {rem, dvd[COORD_W-1]};
        q_bit     = (trial >= DIV_V);
        rem_nxt   = q_bit ? COORD_W'(trial - DIV_V) : COORD_W'(trial);
        quo_nxt   = {quo[COORD_W-2:0], q_bit};
        last_iter = (cnt == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath control.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        next_y    = 1'b0;
        iter      = 1'b0;
        set_pend  = 1'b0;
        clr_pend  = 1'b0;
        commit    = 1'b0;
        src_x     = xpos;
        src_y     = ypos;
        case (state)
            S_IDLE: begin
                if (req) begin
                    start     = 1'b1;
                    state_nxt = S_DIV_X;
                end
            end
            S_DIV_X: begin
                iter     = 1'b1;
                set_pend = req;
                if (last_iter) begin
                    next_y    = 1'b1;
                    state_nxt = S_DIV_Y;
                end
            end
            S_DIV_Y: begin
                iter     = 1'b1;
                set_pend = req;
                if (last_iter) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit    = 1'b1;
                state_nxt = S_IDLE;
                // a live request beats the stored one; either way pending is consumed
                if (req) begin
                    start     = 1'b1;
                    clr_pend  = 1'b1;
                    state_nxt = S_DIV_X;
                end else if (pend) begin
                    start     = 1'b1;
                    clr_pend  = 1'b1;
                    src_x     = pend_x;
                    src_y     = pend_y;
                    state_nxt = S_DIV_X;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pending request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            pend_x <= '0;
            pend_y <= '0;
        end else if (set_pend) begin
            pend   <= 1'b1;
            pend_x <= xpos;
            pend_y <= ypos;
        end else if (clr_pend) begin
            pend   <= 1'b0;
        end
    end

    // Shared divider: X first, then the latched Y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd   <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            lat_y <= '0;
            qx    <= '0;
        end else if (start) begin
            dvd   <= src_x;
            lat_y <= src_y;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
        end else if (iter) begin
            if (last_iter) begin
                cnt <= '0;
                rem <= '0;
                if (next_y) begin
                    qx  <= quo_nxt;
                    dvd <= lat_y;
                    quo <= '0;
                end else begin
                    // Y quotient stays in quo until COMMIT
                    quo <= quo_nxt;
                    dvd <= '0;
                end
            end else begin
                dvd <= {dvd[COORD_W-2:0], 1'b0};
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered outputs; both axes change together, only on COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_scale_pos <= '0;
            y_scale_pos <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= commit;
            busy <= (state_nxt != S_IDLE);
            if (commit) begin
                // clamp at full quotient width before narrowing
                x_scale_pos <= (qx > XMAX_V)  ? OUT_W'(XMAX_V) : OUT_W'(qx);
                y_scale_pos <= (quo > YMAX_V) ? OUT_W'(YMAX_V) : OUT_W'(quo);
            end
        end
    end

endmodule
